// File: rtl/pma_seq_checker.sv
// pma_seq_checker: area-lean PMA region check shared by fetch (id 0) and load/store (id 1),
// scanning one base/length rule per cycle. Define PMA_SEQ_STATS_EN for saturating usage counters.
module pma_seq_checker #(
  parameter int unsigned NR_RULES     = 16,
  parameter bit          EMPTY_IS_HIT = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [4:0]               nr_rules_i,
  input  logic [NR_RULES*64-1:0]   rule_base_i,
  input  logic [NR_RULES*64-1:0]   rule_len_i,
  input  logic [1:0]               req_valid_i,
  input  logic [2*64-1:0]          req_addr_i,
  output logic [1:0]               req_ready_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_id_o,
  output logic                     rsp_hit_o
`ifdef PMA_SEQ_STATS_EN
  ,
  output logic [31:0]              stat_checks_o,
  output logic [31:0]              stat_cycles_o,
  output logic [31:0]              stat_hits_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } stateT;

  localparam logic [4:0] MaxCount = 5'(NR_RULES);

  stateT       stateReg;
  stateT       stateNext;
  logic [4:0]  idxReg;
  logic        rrReg;
  logic [63:0] addrReg;
  logic        rspIdReg;
  logic        rspHitReg;

  logic [63:0] ruleBase [NR_RULES];
  logic [63:0] ruleLen  [NR_RULES];
  logic [4:0]  effCount;
  logic [63:0] curBase;
  logic [63:0] curLen;
  logic [64:0] curEnd;
  logic        curMatch;
  logic        lastRule;
  logic [1:0]  grantVec;
  logic [1:0]  reqReady;
  logic        rspValid;
  logic        grantFire;
  logic        scanActive;
  logic        handshake;

  // Unpack the flat rule buses into per-rule views.
  generate
    for (genvar gi = 0; gi < NR_RULES; gi++) begin : g_rules
      assign ruleBase[gi] = rule_base_i[64*gi +: 64];
      assign ruleLen[gi]  = rule_len_i[64*gi +: 64];
    end
  endgenerate

  assign effCount = (nr_rules_i > MaxCount) ? MaxCount : nr_rules_i;

  // Single comparator: mux out the rule under test instead of checking all rules in parallel.
  always_comb begin
    curBase = '0;
    curLen  = '0;
    for (int k = 0; k < NR_RULES; k++) begin
      if (idxReg == 5'(k)) begin
        curBase = ruleBase[k];
        curLen  = ruleLen[k];
      end
    end
  end

  assign curEnd   = {1'b0, curBase} + {1'b0, curLen};
  assign curMatch = (addrReg >= curBase) && ({1'b0, addrReg} < curEnd);
  // >= rather than == so a count that shrinks mid-scan still terminates.
  assign lastRule = (({1'b0, idxReg} + 6'd1) >= {1'b0, effCount});

  always_comb begin
    grantVec = 2'b00;
    case (req_valid_i)
      2'b01:   grantVec = 2'b01;
      2'b10:   grantVec = 2'b10;
      2'b11:   grantVec = rrReg ? 2'b10 : 2'b01;
      default: grantVec = 2'b00;
    endcase
  end

  always_comb begin
    stateNext = stateReg;
    reqReady  = 2'b00;
    rspValid  = 1'b0;
    case (stateReg)
      IDLE: begin
        reqReady = grantVec;
        if (grantVec != 2'b00) begin
          stateNext = (effCount == 5'd0) ? RESP : SCAN;
        end
      end
      SCAN: begin
        if (curMatch || lastRule) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        rspValid = 1'b1;
        if (rsp_ready_i) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (rst_i || flush_i) begin
      stateNext = IDLE;
      reqReady  = 2'b00;
      rspValid  = 1'b0;
    end
  end

  assign grantFire  = (stateReg == IDLE) && (reqReady != 2'b00);
  assign scanActive = (stateReg == SCAN) && !flush_i;
  assign handshake  = rspValid && rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg  <= IDLE;
      idxReg    <= '0;
      rrReg     <= 1'b0;
      addrReg   <= '0;
      rspIdReg  <= 1'b0;
      rspHitReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (grantFire) begin
        addrReg   <= reqReady[1] ? req_addr_i[127:64] : req_addr_i[63:0];
        rspIdReg  <= reqReady[1];
        idxReg    <= '0;
        rspHitReg <= EMPTY_IS_HIT;
      end else if (scanActive) begin
        if (curMatch) begin
          rspHitReg <= 1'b1;
        end else if (lastRule) begin
          rspHitReg <= 1'b0;
        end else begin
          idxReg <= idxReg + 5'd1;
        end
      end
      if (handshake) begin
        rrReg <= ~rspIdReg;
      end
    end
  end

  assign req_ready_o = reqReady;
  assign rsp_valid_o = rspValid;
  assign rsp_id_o    = rspIdReg;
  assign rsp_hit_o   = rspHitReg;

`ifdef PMA_SEQ_STATS_EN
  logic [31:0] statChecksReg;
  logic [31:0] statCyclesReg;
  logic [31:0] statHitsReg;

  // Counters survive flush; only reset clears them, and all saturate at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      statChecksReg <= '0;
      statCyclesReg <= '0;
      statHitsReg   <= '0;
    end else begin
      if (handshake && (statChecksReg != '1)) begin
        statChecksReg <= statChecksReg + 32'd1;
      end
      if ((stateReg == SCAN) && (statCyclesReg != '1)) begin
        statCyclesReg <= statCyclesReg + 32'd1;
      end
      if (handshake && rspHitReg && (statHitsReg != '1)) begin
        statHitsReg <= statHitsReg + 32'd1;
      end
    end
  end

  assign stat_checks_o = statChecksReg;
  assign stat_cycles_o = statCyclesReg;
  assign stat_hits_o   = statHitsReg;
`endif

endmodule

// File: tb/tb_pma_seq_checker.sv
// Randomized and directed bench for pma_seq_checker; two instances cover EMPTY_IS_HIT=0 and =1.
module tb_pma_seq_checker;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [4:0]    nrRules = '0;
  logic [NR*64-1:0] ruleBaseBus = '0;
  logic [NR*64-1:0] ruleLenBus = '0;
  logic [1:0]    reqValid = 2'b00;
  logic [127:0]  reqAddr = '0;
  logic          rspReady = 1'b0;
  logic [1:0]    reqReady0, reqReady1;
  logic          rspValid0, rspValid1;
  logic          rspId0, rspId1;
  logic          rspHit0, rspHit1;
`ifdef PMA_SEQ_STATS_EN
  logic [31:0]   statChecks0, statCycles0, statHits0;
  logic [31:0]   statChecks1, statCycles1, statHits1;
`endif

  int passCount = 0;
  int checkCount = 0;
  logic [63:0] tbBase [NR];
  logic [63:0] tbLen  [NR];

  always #5 clk = ~clk;

  pma_seq_checker #(.NR_RULES(NR), .EMPTY_IS_HIT(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .nr_rules_i(nrRules),
    .rule_base_i(ruleBaseBus), .rule_len_i(ruleLenBus),
    .req_valid_i(reqValid), .req_addr_i(reqAddr), .req_ready_o(reqReady0),
    .rsp_valid_o(rspValid0), .rsp_ready_i(rspReady), .rsp_id_o(rspId0), .rsp_hit_o(rspHit0)
`ifdef PMA_SEQ_STATS_EN
    , .stat_checks_o(statChecks0), .stat_cycles_o(statCycles0), .stat_hits_o(statHits0)
`endif
  );

  pma_seq_checker #(.NR_RULES(NR), .EMPTY_IS_HIT(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .nr_rules_i(nrRules),
    .rule_base_i(ruleBaseBus), .rule_len_i(ruleLenBus),
    .req_valid_i(reqValid), .req_addr_i(reqAddr), .req_ready_o(reqReady1),
    .rsp_valid_o(rspValid1), .rsp_ready_i(rspReady), .rsp_id_o(rspId1), .rsp_hit_o(rspHit1)
`ifdef PMA_SEQ_STATS_EN
    , .stat_checks_o(statChecks1), .stat_cycles_o(statCycles1), .stat_hits_o(statHits1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRules();
    for (int k = 0; k < NR; k++) begin
      tbBase[k] = '0;
      tbLen[k]  = '0;
    end
  endtask

  task automatic loadRules(input int nr);
    for (int k = 0; k < NR; k++) begin
      ruleBaseBus[64*k +: 64] = tbBase[k];
      ruleLenBus[64*k +: 64]  = tbLen[k];
    end
    nrRules = 5'(nr);
  endtask

  // Reference: first rule (in table order) whose [base, base+len) holds addr, 65-bit end.
  function automatic void refCheck(input logic [63:0] addr, input int nr, input bit emptyHit,
                                   output bit hit, output int lat);
    int cnt;
    logic [64:0] lim;
    cnt = (nr > NR) ? NR : nr;
    hit = 1'b0;
    lat = 1 + cnt;
    if (cnt == 0) begin
      hit = emptyHit;
      lat = 1;
      return;
    end
    for (int k = 0; k < cnt; k++) begin
      lim = {1'b0, tbBase[k]} + {1'b0, tbLen[k]};
      if (addr >= tbBase[k] && {1'b0, addr} < lim) begin
        hit = 1'b1;
        lat = 2 + k;
        return;
      end
    end
  endfunction

  task automatic runCheck(input int port, input logic [63:0] addr, input int hold, input string name,
                          input bit expHit, input bit expHit1, input int expLat);
    int waited;
    int lat;
    bit readyLeak;
    bit unstable;
    logic expId;
    logic [1:0] expGrant;
    expId = (port == 1);
    expGrant = (port == 1) ? 2'b10 : 2'b01;
    if (port == 1) reqAddr[127:64] = addr;
    else reqAddr[63:0] = addr;
    reqValid = expGrant;
    rspReady = 1'b0;
    #1;
    waited = 0;
    while (reqReady0 == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    checkCount++;
    if (reqReady0 !== expGrant) $display("FAIL %s grant: got %b expected %b", name, reqReady0, expGrant);
    else passCount++;
    tick();
    reqValid = 2'b00;
    #1;
    lat = 1;
    readyLeak = 1'b0;
    while (rspValid0 !== 1'b1 && lat < 40) begin
      if (reqReady0 !== 2'b00) readyLeak = 1'b1;
      tick();
      lat++;
    end
    if (reqReady0 !== 2'b00) readyLeak = 1'b1;
    checkCount++;
    if (lat !== expLat) $display("FAIL %s latency: got %0d expected %0d", name, lat, expLat);
    else passCount++;
    checkCount++;
    if (rspId0 !== expId) $display("FAIL %s id: got %b expected %b", name, rspId0, expId);
    else passCount++;
    checkCount++;
    if (rspHit0 !== expHit) $display("FAIL %s hit: got %b expected %b", name, rspHit0, expHit);
    else passCount++;
    checkCount++;
    if (rspValid1 !== 1'b1 || rspHit1 !== expHit1)
      $display("FAIL %s empty_hit_inst: got valid=%b hit=%b expected valid=1 hit=%b", name, rspValid1, rspHit1, expHit1);
    else passCount++;
    checkCount++;
    if (readyLeak !== 1'b0) $display("FAIL %s req_ready_busy: got leak=%b expected 0", name, readyLeak);
    else passCount++;
    if (hold > 0) begin
      unstable = 1'b0;
      for (int d = 0; d < hold; d++) begin
        tick();
        if (rspValid0 !== 1'b1 || rspId0 !== expId || rspHit0 !== expHit || reqReady0 !== 2'b00)
          unstable = 1'b1;
      end
      checkCount++;
      if (unstable !== 1'b0) $display("FAIL %s backpressure_hold: got unstable=%b expected 0", name, unstable);
      else passCount++;
    end
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    #1;
    checkCount++;
    if (rspValid0 !== 1'b0 || rspValid1 !== 1'b0)
      $display("FAIL %s rsp_release: got valid=%b/%b expected 0/0", name, rspValid0, rspValid1);
    else passCount++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqValid = 2'b11;
    tick();
    tick();
    checkCount++;
    if (reqReady0 !== 2'b00) $display("FAIL reset req_ready: got %b expected 00", reqReady0);
    else passCount++;
    checkCount++;
    if (rspValid0 !== 1'b0 || rspId0 !== 1'b0 || rspHit0 !== 1'b0)
      $display("FAIL reset rsp: got valid=%b id=%b hit=%b expected 0 0 0", rspValid0, rspId0, rspHit0);
    else passCount++;
    reqValid = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic setBasicRules();
    clearRules();
    tbBase[0] = 64'h0000_0000_8000_0000;
    tbLen[0]  = 64'h0000_0000_4000_0000;
    loadRules(1);
  endtask

  task automatic test_region_basic();
    setBasicRules();
    runCheck(1, 64'h0000_0000_8000_1000, 0, "basic_inside", 1'b1, 1'b1, 2);
    runCheck(0, 64'h0000_0000_C000_0000, 0, "basic_exact_end", 1'b0, 1'b0, 2);
    runCheck(0, 64'h0000_0000_7FFF_FFFF, 0, "basic_below", 1'b0, 1'b0, 2);
  endtask

  task automatic test_empty();
    setBasicRules();
    nrRules = 5'd0;
    runCheck(0, 64'h0000_0000_8000_1000, 0, "empty_count", 1'b0, 1'b1, 1);
  endtask

  task automatic test_overflow();
    clearRules();
    tbBase[0] = 64'hFFFF_FFFF_FFFF_F000;
    tbLen[0]  = 64'h0000_0000_0000_1000;
    loadRules(1);
    runCheck(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "ovf_top", 1'b1, 1'b1, 2);
    runCheck(0, 64'h0000_0000_0000_0000, 0, "ovf_zero", 1'b0, 1'b0, 2);
  endtask

  task automatic test_backpressure();
    setBasicRules();
    runCheck(1, 64'h0000_0000_9000_0000, 3, "bp_hit", 1'b1, 1'b1, 2);
    runCheck(0, 64'h0000_0000_1000_0000, 3, "bp_miss", 1'b0, 1'b0, 2);
  endtask

  task automatic test_arbitration();
    logic [3:0] gotSeq;
    int nG;
    bit bad;
    clearRules();
    tbBase[0] = 64'h1000;
    tbLen[0]  = 64'h10;
    loadRules(1);
    rst = 1'b1;
    reqValid = 2'b11;
    rspReady = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    gotSeq = 4'bxxxx;
    nG = 0;
    bad = 1'b0;
    for (int c = 0; c < 60 && nG < 4; c++) begin
      if (reqReady0 != 2'b00) begin
        gotSeq[nG] = reqReady0[1];
        nG++;
        if (!$onehot0(reqReady0) || rspValid0) bad = 1'b1;
      end
      tick();
    end
    reqValid = 2'b00;
    checkCount++;
    if (gotSeq !== 4'b1010) $display("FAIL arb_order: got %b expected 1010 (lsb first grant)", gotSeq);
    else passCount++;
    checkCount++;
    if (bad !== 1'b0) $display("FAIL arb_ready_exclusive: got bad=%b expected 0", bad);
    else passCount++;
    for (int c = 0; c < 10; c++) tick();
    rspReady = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int waited;
    bit leak;
    clearRules();
    loadRules(16);
    // rr becomes 1 after a completed port-0 check.
    runCheck(0, 64'h1234, 0, "flush_pre", 1'b0, 1'b0, 17);
    reqValid = 2'b11;
    flush = 1'b1;
    #1;
    checkCount++;
    if (reqReady0 !== 2'b00) $display("FAIL flush_idle_ready: got %b expected 00", reqReady0);
    else passCount++;
    flush = 1'b0;
    reqValid = 2'b10;
    reqAddr[127:64] = 64'h5678;
    #1;
    waited = 0;
    while (reqReady0 == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    leak = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (reqReady0 !== 2'b00 || rspValid0 !== 1'b0) leak = 1'b1;
      tick();
    end
    checkCount++;
    if (leak !== 1'b0) $display("FAIL scan_ready_zero: got leak=%b expected 0", leak);
    else passCount++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    reqValid = 2'b11;
    #1;
    checkCount++;
    if (reqReady0 !== 2'b10 || rspValid0 !== 1'b0)
      $display("FAIL flush_scan_idle_rr: got ready=%b valid=%b expected 10 0", reqReady0, rspValid0);
    else passCount++;
    reqValid = 2'b00;
    leak = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rspValid0 !== 1'b0) leak = 1'b1;
    end
    checkCount++;
    if (leak !== 1'b0) $display("FAIL flush_no_rsp: got rsp seen=%b expected 0", leak);
    else passCount++;
  endtask

  task automatic test_reset_in_resp();
    int waited;
    setBasicRules();
    reqAddr[127:64] = 64'h0000_0000_8000_1000;
    reqValid = 2'b10;
    #1;
    waited = 0;
    while (reqReady0 == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    reqValid = 2'b00;
    #1;
    waited = 0;
    while (rspValid0 !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checkCount++;
    if (rspValid0 !== 1'b1 || rspId0 !== 1'b1)
      $display("FAIL rstresp_reach: got valid=%b id=%b expected 1 1", rspValid0, rspId0);
    else passCount++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkCount++;
    if (rspValid0 !== 1'b0 || rspId0 !== 1'b0 || rspHit0 !== 1'b0)
      $display("FAIL rstresp_drop: got valid=%b id=%b hit=%b expected 0 0 0", rspValid0, rspId0, rspHit0);
    else passCount++;
    tick();
  endtask

  task automatic test_random();
    int nr;
    int j;
    int port;
    logic [63:0] addr;
    bit h0, h1;
    int lat0, lat1;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NR; k++) begin
        case ($urandom_range(0, 3))
          0: tbBase[k] = {$urandom(), $urandom()};
          1: tbBase[k] = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 8191));
          2: tbBase[k] = {32'h0, $urandom()};
          default: tbBase[k] = 64'($urandom_range(0, 65535));
        endcase
        case ($urandom_range(0, 3))
          0: tbLen[k] = '0;
          1: tbLen[k] = 64'($urandom_range(1, 4096));
          2: tbLen[k] = {32'h0, $urandom()};
          default: tbLen[k] = {$urandom(), $urandom()};
        endcase
      end
      nr = $urandom_range(0, 31);
      loadRules(nr);
      j = $urandom_range(0, NR - 1);
      case ($urandom_range(0, 5))
        0: addr = tbBase[j] - 64'd1;
        1: addr = tbBase[j];
        2: addr = tbBase[j] + tbLen[j] - 64'd1;
        3: addr = tbBase[j] + tbLen[j];
        4: addr = tbBase[j] + (tbLen[j] >> 1);
        default: addr = {$urandom(), $urandom()};
      endcase
      port = $urandom_range(0, 1);
      refCheck(addr, nr, 1'b0, h0, lat0);
      refCheck(addr, nr, 1'b1, h1, lat1);
      runCheck(port, addr, $urandom_range(0, 3), $sformatf("rand%0d", it), h0, h1, lat0);
    end
  endtask

`ifdef PMA_SEQ_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setBasicRules();
    runCheck(1, 64'h0000_0000_8000_1000, 0, "stats_hit", 1'b1, 1'b1, 2);
    runCheck(0, 64'h0000_0000_7FFF_FFFF, 0, "stats_miss", 1'b0, 1'b0, 2);
    checkCount++;
    if (statChecks0 !== 32'd2 || statHits0 !== 32'd1 || statCycles0 !== 32'd2)
      $display("FAIL stats: got checks=%0d hits=%0d cycles=%0d expected 2 1 2", statChecks0, statHits0, statCycles0);
    else passCount++;
  endtask
`endif

  initial begin
    clearRules();
    test_reset();
    test_region_basic();
    test_empty();
    test_overflow();
    test_backpressure();
    test_arbitration();
    test_flush();
    test_reset_in_resp();
    test_random();
`ifdef PMA_SEQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pma_seq_checker.md
Name: pma_seq_checker

Overview:
- Sequential, area-lean PMA region checker shared between two requesters: port 0 is fetch, port 1 is load/store.
- Holds no rule storage. It scans the rule table driven from the configuration (base/length pairs, up to NrMaxRules) one rule per cycle and reports whether the address falls inside any region.
- Intended for FpgaEn builds, where the fully parallel 16-comparator check costs too many LUTs.
- One instance per region class: non-idempotent, execute or cached.

Parameters:
- NR_RULES, 16, physical size of the rule arrays; must be 1..16.
- EMPTY_IS_HIT, 0, result returned when the effective rule count is 0. Use 1 for the execute class, 0 otherwise.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  abort any in-flight check
- nr_rules_i  in  5  number of active rules; values above NR_RULES are clamped to NR_RULES
- rule_base_i  in  NR_RULES*64  region base addresses, rule k at bits [64k+63:64k]
- rule_len_i  in  NR_RULES*64  region lengths, same packing as rule_base_i
- req_valid_i  in  2  per-requester request valid
- req_addr_i  in  2*64  per-requester address
- req_ready_o  out  2  per-requester grant/accept
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result accepted
- rsp_id_o  out  1  requester index that owns the result
- rsp_hit_o  out  1  1 = address lies inside some active region

Behaviour:
- Match test for rule k: addr >= base_k AND {1'b0,addr} < (65-bit base_k + len_k). The sum is computed in 65 bits, so it never wraps. A length of 0 never matches.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready_o is combinational; at most one bit is set.
  - If exactly one req_valid_i bit is set, that requester is granted.
  - If both are set, the round-robin pointer rr picks the winner.
  - On grant: latch the address and id, idx<=0, then:
    - if the effective count is 0: go to RESP with hit=EMPTY_IS_HIT;
    - otherwise: go to SCAN.
- SCAN:
  - Each cycle, evaluate rule idx against the latched address.
  - Match: go to RESP with hit=1 (early exit).
  - Last active rule (idx==count-1) and no match: go to RESP with hit=0.
  - Otherwise: idx++.
  - req_ready_o=0 throughout.
- RESP:
  - rsp_valid_o=1; rsp_id_o and rsp_hit_o are held stable until rsp_ready_i.
  - On rsp_ready_i: go to IDLE and set rr<=~rsp_id.
  - No new grant is issued in the same cycle as the response handshake.
- Latency:
  - grant in cycle t, first match at rule k: rsp_valid_o rises in cycle t+2+k;
  - no match: t+1+count;
  - count 0: t+1.
- Throughput: one check in flight.
- Rule inputs and nr_rules_i are sampled live during SCAN. They must stay stable between grant and response; otherwise the result is undefined but the FSM still terminates, because idx is compared with >= against the clamped count.
- flush_i:
  - in any state: next state is IDLE; no response is produced; rr is unchanged;
  - in IDLE: req_ready_o is forced to 0.
- Reset: state=IDLE, rr=0, idx=0, rsp_valid_o=0, rsp_id_o=0, rsp_hit_o=0, req_ready_o=0. Reset mid-scan drops the check.
- Flush and reset take priority over all other transitions.

Optional Feature:
- Macro PMA_SEQ_STATS_EN.
- Defined: adds the following ports, each cleared on rst_i (not on flush_i):
  - stat_checks_o out 32: count of completed response handshakes;
  - stat_cycles_o out 32: count of cycles spent in SCAN;
  - stat_hits_o out 32: count of completed responses with hit=1.
  - All three counters saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Rules {base 0x8000_0000, len 0x4000_0000}, nr_rules=1; port1 addr 0x8000_1000 -> rsp_valid 2 cycles after grant, hit=1, id=1.
- Same rule table, addr 0xC000_0000 (exact end) -> hit=0, rsp_valid 2 cycles after grant. Addr 0x7FFF_FFFF -> hit=0.
- nr_rules=0 with EMPTY_IS_HIT=1 -> hit=1 one cycle after grant. Repeat with EMPTY_IS_HIT=0 -> hit=0.
- Overflow guard: base 0xFFFF_FFFF_FFFF_F000, len 0x1000; addr 0xFFFF_FFFF_FFFF_FFFF -> hit=1. Addr 0x0 -> hit=0.
- Arbitration and backpressure:
  - both ports valid continuously from reset: grants go 0,1,0,1;
  - with rsp_ready low for 3 cycles, rsp_valid, rsp_id and rsp_hit stay stable;
  - req_ready stays 0 during SCAN and RESP.
- Abort:
  - flush_i during SCAN at idx=5 of 16 -> next cycle IDLE, no rsp_valid, rr unchanged;
  - rst_i during RESP -> rsp_valid_o=0 the next cycle;
  - with PMA_SEQ_STATS_EN: counters report checks=2, hits=1 after the two preceding completed checks.
